// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: EX forwarding, load-use and MD scoreboard stalls, redirect flush.
// Define PIPE_HAZARD_PERF_EN to build the saturating stall performance counter.
module pipe_hazard_ctrl #(
    parameter int RW     = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RW-1:0]    id_rs,
    input  logic [RW-1:0]    id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_regwrite,
    input  logic [RW-1:0]    id_writereg,
    input  logic             id_md,
    input  logic [RW-1:0]    ex_rs,
    input  logic [RW-1:0]    ex_rt,
    input  logic             ex_memtoreg,
    input  logic [RW-1:0]    ex_writereg,
    input  logic             ex_md_start,
    input  logic             ex_redirect,
    input  logic             mem_regwrite,
    input  logic [RW-1:0]    mem_writereg,
    input  logic             wb_regwrite,
    input  logic [RW-1:0]    wb_writereg,
    output logic             keep_write,
    output logic             flush_id,
    output logic             bubble_ex,
    output logic [1:0]       fwd_rs,
    output logic [1:0]       fwd_rt,
    output logic             md_busy,
    output logic             md_done,
    output logic [RW-1:0]    md_dest,
    output logic             md_overlap_err,
    output logic [CNT_W-1:0] stall_count
);
    localparam logic [3:0] LP_LAT = 4'(MD_LAT);

    logic [3:0]    r_md_cnt;
    logic [RW-1:0] r_md_dest;
    logic          r_md_err;
    logic          w_md_pending;
    logic          w_load_use;
    logic          w_md_hazard;
    logic          w_stall;

    assign w_md_pending   = (r_md_cnt != 4'd0);
    assign md_busy        = reset && w_md_pending;
    assign md_done        = reset && (r_md_cnt == 4'd1);
    assign md_dest        = r_md_dest;
    assign md_overlap_err = r_md_err;

    assign w_load_use = ex_memtoreg && (ex_writereg != '0) &&
                        ((id_uses_rs && (id_rs == ex_writereg)) ||
                         (id_uses_rt && (id_rt == ex_writereg)));

    // Structural MD conflicts stall even when the pending MD writes r0.
    assign w_md_hazard = w_md_pending &&
                         (id_md ||
                          ((r_md_dest != '0) &&
                           ((id_uses_rs && (id_rs == r_md_dest)) ||
                            (id_uses_rt && (id_rt == r_md_dest)) ||
                            (id_regwrite && (id_writereg == r_md_dest)))));

    assign w_stall = w_load_use || w_md_hazard;

    always_comb begin
        keep_write = 1'b1;
        flush_id   = 1'b0;
        bubble_ex  = 1'b0;
        if (!reset || ex_redirect) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
        end else if (w_stall) begin
            keep_write = 1'b0;
            bubble_ex  = 1'b1;
        end
    end

    always_comb begin
        fwd_rs = 2'b00;
        fwd_rt = 2'b00;
        if (reset) begin
            if (mem_regwrite && (mem_writereg == ex_rs) && (ex_rs != '0))
                fwd_rs = 2'b10;
            else if (wb_regwrite && (wb_writereg == ex_rs) && (ex_rs != '0))
                fwd_rs = 2'b01;
            if (mem_regwrite && (mem_writereg == ex_rt) && (ex_rt != '0))
                fwd_rt = 2'b10;
            else if (wb_regwrite && (wb_writereg == ex_rt) && (ex_rt != '0))
                fwd_rt = 2'b01;
        end
    end

    // A start that arrives while an op is outstanding is dropped; the older op keeps counting down.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_md_cnt  <= 4'd0;
            r_md_dest <= '0;
            r_md_err  <= 1'b0;
        end else begin
            if (ex_md_start && !w_md_pending) begin
                r_md_cnt  <= LP_LAT;
                r_md_dest <= ex_writereg;
            end else if (w_md_pending) begin
                r_md_cnt <= r_md_cnt - 4'd1;
            end
            if (ex_md_start && w_md_pending)
                r_md_err <= 1'b1;
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (!reset)
            r_stall_count <= '0;
        else if (w_stall && !ex_redirect && (r_stall_count != '1))
            r_stall_count <= r_stall_count + 1'b1;
    end

    assign stall_count = r_stall_count;
`else
    assign stall_count = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline hazard controller for the 5-stage MIPS core.
- Replaces the separate forwarding and load-use hazard units with one block.
- Adds a scoreboard for a multi-cycle MD unit (mult/div) with configurable latency, WAW protection and redirect-flush priority.
- Generates all PC/IF-ID/ID-EX hold and nullify controls plus EX-stage forwarding selects.

Parameters:
- RW, 5, register-address width; register 0 is hard-wired zero.
- MD_LAT, 4, MD unit latency in cycles from issue in EX to result write (legal range 2..15).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-low reset
- id_rs, id_rt  in  RW  ID-stage source registers
- id_uses_rs, id_uses_rt  in  1  ID instruction actually reads rs / rt
- id_regwrite  in  1  ID instruction writes a register
- id_writereg  in  RW  ID destination register
- id_md  in  1  ID instruction is an MD op
- ex_rs, ex_rt  in  RW  EX-stage source registers
- ex_memtoreg  in  1  EX instruction is a load
- ex_writereg  in  RW  EX destination register
- ex_md_start  in  1  MD op issuing in EX this cycle
- ex_redirect  in  1  taken branch or jump resolved in EX
- mem_regwrite  in  1  MEM-stage register write enable
- mem_writereg  in  RW  MEM-stage destination register
- wb_regwrite  in  1  WB-stage register write enable
- wb_writereg  in  RW  WB-stage destination register
- keep_write  out  1  0 = hold PC and IF/ID
- flush_id  out  1  nullify IF/ID
- bubble_ex  out  1  nullify ID/EX
- fwd_rs, fwd_rt  out  2  00 regfile, 10 MEM aluout, 01 WB result
- md_busy  out  1  MD result outstanding
- md_done  out  1  MD result write this cycle
- md_dest  out  RW  pending MD destination register
- md_overlap_err  out  1  sticky protocol error
- stall_count  out  CNT_W  count of stall cycles

Behaviour:
- Reset (reset=0 at a clk edge):
  - md_cnt=0, md_dest=0, md_overlap_err=0, stall_count=0.
  - While reset is low: keep_write=1, flush_id=1, bubble_ex=1, fwd_*=00.
  - Reset mid-MD discards the pending op; md_done does not pulse.
- Forwarding (combinational; rs shown, rt identical):
  - fwd_rs=10 if mem_regwrite && mem_writereg==ex_rs && ex_rs!=0.
  - Else fwd_rs=01 if wb_regwrite && wb_writereg==ex_rs && ex_rs!=0.
  - Else 00. MEM has priority over WB.
- Load-use hazard:
  - Condition: ex_memtoreg && ex_writereg!=0 && ((id_uses_rs && id_rs==ex_writereg) || (id_uses_rt && id_rt==ex_writereg)).
  - Stalls exactly 1 cycle.
- MD scoreboard:
  - ex_md_start with md_cnt==0: md_cnt<=MD_LAT, md_dest<=ex_writereg.
  - Otherwise md_cnt decrements while nonzero.
  - md_busy = (md_cnt!=0); md_done = (md_cnt==1).
  - ex_md_start while md_busy: the start is ignored, md_cnt and md_dest are unchanged, md_overlap_err<=1 (sticky until reset).
- MD hazard, while md_busy and md_dest!=0:
  - ID reads md_dest (either used source), or
  - id_regwrite && id_writereg==md_dest (WAW), or
  - id_md (structural; applies regardless of md_dest).
- Stall:
  - stall = load-use hazard OR MD hazard.
  - On stall: keep_write=0, bubble_ex=1, flush_id=0.
  - Release is the cycle after md_done, when md_cnt==0 and the regfile holds the result.
- Redirect:
  - ex_redirect=1 gives flush_id=1, bubble_ex=1, keep_write=1.
  - Redirect overrides stall the same cycle.
  - The scoreboard is not cleared, because the MD op was issued by an older instruction.
- Idle (no hazard, no redirect): keep_write=1, flush_id=0, bubble_ex=0.
- All state updates on posedge clk only.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- Defined: stall_count increments on every cycle with stall=1 && ex_redirect=0 && reset=1. It saturates at all-ones and never wraps.
- Undefined: stall_count is tied to 0 and no counter flops are built.

Test Plan:
- Forwarding priority: EX rs=5, mem_regwrite=1 mem_writereg=5, wb_regwrite=1 wb_writereg=5 -> fwd_rs=10. Drop mem_regwrite -> 01. Set rs=0 -> 00.
- Load-use: ex_memtoreg=1, ex_writereg=8, id_rs=8, id_uses_rs=1 -> one cycle keep_write=0 bubble_ex=1. Same case with id_uses_rs=0 -> no stall.
- MD dependency, MD_LAT=4: ex_md_start at cycle t (dest=9), ID reads 9 from t+1.
  - Required: stall in cycles t+1..t+4, md_done at t+4, keep_write=1 at t+5.
  - Same case with a WAW write to 9 and with id_md=1 -> identical stall.
- Redirect during MD stall: ex_redirect=1 at t+2 -> flush_id=1, bubble_ex=1, keep_write=1 that cycle. md_done still pulses at t+4.
- Overlap and reset: second ex_md_start at t+1 -> md_overlap_err=1 and md_dest is unchanged.
  - Then reset=0 at t+2 -> md_busy=0, md_overlap_err=0, and no md_done.
- With PIPE_HAZARD_PERF_EN, CNT_W=2: five stall cycles -> stall_count 1,2,3,3,3.
  - Without the macro -> stall_count=0 throughout.
